// File: rtl/msx_slot_pkg.sv
// Shared types and helpers for the MSX expanded-slot controller.
package msx_slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } subslot_state_t;

    localparam logic [15:0] SUBSLOT_REG_ADDR = 16'hFFFF;

    // Extract the 2-bit sub-slot code for a 16 KB page from the register.
    function automatic logic [1:0] page_code(input logic [7:0] reg_val, input logic [1:0] page);
        logic [1:0] code;
        case (page)
            2'd0:    code = reg_val[1:0];
            2'd1:    code = reg_val[3:2];
            2'd2:    code = reg_val[5:4];
            default: code = reg_val[7:6];
        endcase
        return code;
    endfunction

endpackage

// File: rtl/msx_subslot_ctrl.sv
// Expanded-slot controller: sub-slot register at REG_ADDR with inverted
// readback, and registered per-page decode onto the secondary SLTSL_n lines.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no register access in progress; DOUT=0, BUSDIR_n=1
// WRITE | register captured on entry; held until WR_n rises or hit drops
// READ  | driving ~SUBSLOT_REG on DOUT with BUSDIR_n=0
module msx_subslot_ctrl
    import msx_slot_pkg::*;
#(
    parameter int          COUNT    = 4,
    parameter logic [15:0] REG_ADDR = SUBSLOT_REG_ADDR
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [15:0]      BUS_ADDR,
    input  logic [7:0]       BUS_DIN,
    input  logic             BUS_RD_n,
    input  logic             BUS_WR_n,
    input  logic             BUS_MERQ_n,
    input  logic             BUS_SLTSL_n,
    input  logic             BUS_RESET_n,
    output logic [COUNT-1:0] SUB_SLTSL_n,
    output logic [7:0]       DOUT,
    output logic             BUSDIR_n,
    output logic [7:0]       SUBSLOT_REG
);

    subslot_state_t state, state_nx;
    logic [7:0]     reg_q, reg_nx;
    logic [7:0]     dout_q, dout_nx;
    logic           busdir_q, busdir_nx;
    logic [COUNT-1:0] sel_q;
    logic           clear;
    logic           hit;
    logic           reg_addr_match;
    logic [1:0]     code;

    // The MSX bus reset behaves exactly like the local reset.
    assign clear          = RESET || !BUS_RESET_n;
    assign reg_addr_match = (BUS_ADDR == REG_ADDR);
    assign hit            = !BUS_SLTSL_n && !BUS_MERQ_n && reg_addr_match;
    assign code           = page_code(reg_q, BUS_ADDR[15:14]);

    // State, register and readback flops.
    always_ff @(posedge CLK) begin
        if (clear) begin
            state    <= IDLE;
            reg_q    <= 8'h00;
            dout_q   <= 8'h00;
            busdir_q <= 1'b1;
        end else begin
            state    <= state_nx;
            reg_q    <= reg_nx;
            dout_q   <= dout_nx;
            busdir_q <= busdir_nx;
        end
    end

    // Bus-cycle next state; a write wins over a simultaneous read strobe.
    always_comb begin
        state_nx  = state;
        reg_nx    = reg_q;
        dout_nx   = 8'h00;
        busdir_nx = 1'b1;
        case (state)
            IDLE: begin
                if (hit && !BUS_WR_n) begin
                    state_nx = WRITE;
                    reg_nx   = BUS_DIN;
                end else if (hit && !BUS_RD_n) begin
                    state_nx  = READ;
                    dout_nx   = ~reg_q;
                    busdir_nx = 1'b0;
                end
            end
            WRITE: begin
                if (BUS_WR_n || !hit) begin
                    state_nx = IDLE;
                end
            end
            READ: begin
                if (BUS_RD_n || !hit) begin
                    state_nx = IDLE;
                end else begin
                    dout_nx   = ~reg_q;
                    busdir_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered sub-slot decode; register accesses never reach a secondary.
    always_ff @(posedge CLK) begin
        if (clear) begin
            sel_q <= '1;
        end else begin
            for (int s = 0; s < COUNT; s++) begin
                sel_q[s] <= !(!BUS_SLTSL_n && !reg_addr_match && (code == 2'(s)));
            end
        end
    end

    assign SUB_SLTSL_n = sel_q;
    assign DOUT        = dout_q;
    assign BUSDIR_n    = busdir_q;
    assign SUBSLOT_REG = reg_q;

endmodule

// File: tb/tb_msx_subslot_ctrl.sv
// Bench for msx_subslot_ctrl: directed scenarios plus randomized bus traffic
// checked against a behavioural model, on a COUNT=4 and a COUNT=2 instance.
module tb_msx_subslot_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] BUS_ADDR;
    logic [7:0]  BUS_DIN;
    logic        BUS_RD_n, BUS_WR_n, BUS_MERQ_n, BUS_SLTSL_n, BUS_RESET_n;

    logic [3:0]  sub4;
    logic [7:0]  dout4, reg4;
    logic        busdir4;
    logic [1:0]  sub2;
    logic [7:0]  dout2, reg2;
    logic        busdir2;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] m_reg;
    logic       m_wr, m_rd;
    logic [7:0] e_dout;
    logic       e_busdir;
    logic [3:0] e_sel4;
    logic [1:0] e_sel2;

    always #5 CLK = ~CLK;

    msx_subslot_ctrl #(.COUNT(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DIN(BUS_DIN),
        .BUS_RD_n(BUS_RD_n), .BUS_WR_n(BUS_WR_n), .BUS_MERQ_n(BUS_MERQ_n),
        .BUS_SLTSL_n(BUS_SLTSL_n), .BUS_RESET_n(BUS_RESET_n),
        .SUB_SLTSL_n(sub4), .DOUT(dout4), .BUSDIR_n(busdir4), .SUBSLOT_REG(reg4)
    );

    msx_subslot_ctrl #(.COUNT(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DIN(BUS_DIN),
        .BUS_RD_n(BUS_RD_n), .BUS_WR_n(BUS_WR_n), .BUS_MERQ_n(BUS_MERQ_n),
        .BUS_SLTSL_n(BUS_SLTSL_n), .BUS_RESET_n(BUS_RESET_n),
        .SUB_SLTSL_n(sub2), .DOUT(dout2), .BUSDIR_n(busdir2), .SUBSLOT_REG(reg2)
    );

    // Advance the model by one edge using the inputs currently on the bus.
    task automatic model_edge();
        logic hit;
        int   code;
        hit = !BUS_SLTSL_n && !BUS_MERQ_n && (BUS_ADDR == 16'hFFFF);
        if (RESET || !BUS_RESET_n) begin
            m_reg = 8'h00; m_wr = 1'b0; m_rd = 1'b0;
            e_dout = 8'h00; e_busdir = 1'b1; e_sel4 = 4'hF; e_sel2 = 2'b11;
        end else begin
            code   = (int'(m_reg) >> (2 * int'(BUS_ADDR[15:14]))) & 3;
            e_sel4 = 4'hF;
            e_sel2 = 2'b11;
            if (!BUS_SLTSL_n && BUS_ADDR != 16'hFFFF) begin
                e_sel4[code] = 1'b0;
                if (code < 2) e_sel2[code] = 1'b0;
            end
            e_dout   = 8'h00;
            e_busdir = 1'b1;
            if (!m_wr && !m_rd && hit && !BUS_WR_n) begin
                m_reg = BUS_DIN;
                m_wr  = 1'b1;
            end else if (m_wr) begin
                if (BUS_WR_n || !hit) m_wr = 1'b0;
            end else if (m_rd) begin
                if (BUS_RD_n || !hit) begin
                    m_rd = 1'b0;
                end else begin
                    e_dout = ~m_reg; e_busdir = 1'b0;
                end
            end else if (hit && !BUS_RD_n) begin
                m_rd = 1'b1; e_dout = ~m_reg; e_busdir = 1'b0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        BUS_RD_n = 1'b1; BUS_WR_n = 1'b1; BUS_MERQ_n = 1'b1; BUS_SLTSL_n = 1'b1;
    endtask

    task automatic bus_access(input logic [15:0] a, input logic rd_n, input logic wr_n);
        BUS_ADDR = a; BUS_SLTSL_n = 1'b0; BUS_MERQ_n = 1'b0;
        BUS_RD_n = rd_n; BUS_WR_n = wr_n;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        BUS_DIN = d;
        bus_access(a, 1'b1, 1'b0);
        step();
        BUS_WR_n = 1'b1;
        step();
        bus_idle();
        step();
    endtask

    task automatic test_reset();
        RESET = 1'b1; step(); step(); RESET = 1'b0;
        vectors++;
        if ({reg4, sub4, dout4, busdir4} !== {8'h00, 4'hF, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_init: got reg=%h sel=%b dout=%h dir=%b expected 00/1111/00/1", reg4, sub4, dout4, busdir4);
        end
        bus_write(16'hFFFF, 8'hE4);
        bus_access(16'hFFFF, 1'b0, 1'b1);
        step();
        vectors++;
        if (busdir4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read_entry: got dir=%b expected 0", busdir4);
        end
        RESET = 1'b1; step(); step();
        vectors++;
        if ({reg4, sub4, dout4, busdir4} !== {8'h00, 4'hF, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid_read: got reg=%h sel=%b dout=%h dir=%b expected 00/1111/00/1", reg4, sub4, dout4, busdir4);
        end
        RESET = 1'b0; bus_idle(); step();
    endtask

    task automatic test_write_read();
        bus_write(16'hFFFF, 8'hE4);
        vectors++;
        if (reg4 !== 8'hE4) begin
            miscompares++;
            $display("FAIL write_reg: got %h expected e4", reg4);
        end
        bus_access(16'hFFFF, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({dout4, busdir4, sub4} !== {8'h1B, 1'b0, 4'hF}) begin
                miscompares++;
                $display("FAIL read_drive%0d: got dout=%h dir=%b sel=%b expected 1b/0/1111", i, dout4, busdir4, sub4);
            end
        end
        BUS_RD_n = 1'b1;
        step();
        vectors++;
        if ({dout4, busdir4} !== {8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL read_release: got dout=%h dir=%b expected 00/1", dout4, busdir4);
        end
        bus_idle(); step();
    endtask

    task automatic test_decode();
        logic [15:0] addrs [5];
        logic [3:0]  exp4 [5];
        logic [1:0]  exp2 [5];
        addrs = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        exp4  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};
        exp2  = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b11};
        for (int i = 0; i < 5; i++) begin
            bus_access(addrs[i], 1'b0, 1'b1);
            step();
            vectors++;
            if ({sub4, sub2} !== {exp4[i], exp2[i]}) begin
                miscompares++;
                $display("FAIL decode_%h: got sel4=%b sel2=%b expected %b/%b", addrs[i], sub4, sub2, exp4[i], exp2[i]);
            end
            bus_idle(); step();
        end
    endtask

    task automatic test_count2();
        bus_write(16'hFFFF, 8'hFF);
        bus_access(16'hC000, 1'b0, 1'b1);
        step();
        vectors++;
        if ({sub2, dout2, busdir2, sub4} !== {2'b11, 8'h00, 1'b1, 4'b0111}) begin
            miscompares++;
            $display("FAIL count2_float: got sel2=%b dout=%h dir=%b sel4=%b expected 11/00/1/0111", sub2, dout2, busdir2, sub4);
        end
        bus_idle(); step();
    endtask

    task automatic test_din_change();
        BUS_DIN = 8'h55;
        bus_access(16'hFFFF, 1'b1, 1'b0);
        step();
        BUS_DIN = 8'hAA;
        step();
        vectors++;
        if (reg4 !== 8'h55) begin
            miscompares++;
            $display("FAIL din_change_held: got %h expected 55", reg4);
        end
        BUS_WR_n = 1'b1; step();
        BUS_WR_n = 1'b0; step();
        vectors++;
        if (reg4 !== 8'hAA) begin
            miscompares++;
            $display("FAIL din_second_write: got %h expected aa", reg4);
        end
        bus_idle(); step();
    endtask

    task automatic test_bus_reset();
        bus_write(16'hFFFF, 8'hE4);
        BUS_RESET_n = 1'b0; step(); BUS_RESET_n = 1'b1;
        vectors++;
        if (reg4 !== 8'h00) begin
            miscompares++;
            $display("FAIL bus_reset_reg: got %h expected 00", reg4);
        end
        bus_access(16'h4000, 1'b0, 1'b1);
        step();
        vectors++;
        if (sub4 !== 4'b1110) begin
            miscompares++;
            $display("FAIL bus_reset_decode: got %b expected 1110", sub4);
        end
        bus_idle(); step();
    endtask

    task automatic test_back_to_back();
        BUS_DIN = 8'hC0;
        bus_access(16'hFFFF, 1'b1, 1'b0);
        step();
        bus_access(16'hC000, 1'b0, 1'b1);
        step();
        vectors++;
        if (sub4 !== 4'b0111) begin
            miscompares++;
            $display("FAIL write_then_page3: got %b expected 0111", sub4);
        end
        bus_idle(); step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                if ($urandom_range(3, 0) == 0) BUS_ADDR = 16'hFFFF;
                else                           BUS_ADDR = 16'($urandom);
                BUS_DIN     = 8'($urandom);
                BUS_SLTSL_n = ($urandom_range(3, 0) == 0);
                BUS_MERQ_n  = ($urandom_range(3, 0) == 0);
                BUS_RD_n    = ($urandom_range(1, 0) == 0);
                BUS_WR_n    = ($urandom_range(2, 0) != 0);
                BUS_RESET_n = ($urandom_range(63, 0) != 0);
                RESET       = ($urandom_range(127, 0) == 0);
            end
            step();
            vectors++;
            if ({sub4, dout4, busdir4, reg4} !== {e_sel4, e_dout, e_busdir, m_reg}) begin
                miscompares++;
                $display("FAIL rand4 n=%0d: got sel=%b dout=%h dir=%b reg=%h expected %b/%h/%b/%h",
                         n, sub4, dout4, busdir4, reg4, e_sel4, e_dout, e_busdir, m_reg);
            end
            vectors++;
            if ({sub2, dout2, busdir2, reg2} !== {e_sel2, e_dout, e_busdir, m_reg}) begin
                miscompares++;
                $display("FAIL rand2 n=%0d: got sel=%b dout=%h dir=%b reg=%h expected %b/%h/%b/%h",
                         n, sub2, dout2, busdir2, reg2, e_sel2, e_dout, e_busdir, m_reg);
            end
        end
        RESET = 1'b0; BUS_RESET_n = 1'b1; bus_idle(); step();
    endtask

    initial begin
        RESET = 1'b1; BUS_RESET_n = 1'b1;
        BUS_ADDR = 16'h0000; BUS_DIN = 8'h00;
        bus_idle();
        m_reg = 8'h00; m_wr = 1'b0; m_rd = 1'b0;
        e_dout = 8'h00; e_busdir = 1'b1; e_sel4 = 4'hF; e_sel2 = 2'b11;

        test_reset();
        test_write_read();
        test_decode();
        test_count2();
        test_din_change();
        test_bus_reset();
        test_back_to_back();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
